// File: rtl/cpu_sram_arbiter.sv
// Two-port (fetch/load-store) to one-port SRAM-like arbiter with in-order response steering.
// Optional macro ARB_ROUND_ROBIN_EN: alternate between ports on contention instead of data-first.
module cpu_sram_arbiter #(
   parameter int MAX_OUTST = 2,
   parameter int ADDR_W    = 32,
   parameter int DATA_W    = 32
) (
   input  logic                clk,
   input  logic                resetn,
   input  logic                inst_req,
   input  logic [ADDR_W-1:0]   inst_addr,
   output logic                inst_addr_ok,
   output logic                inst_data_ok,
   output logic [DATA_W-1:0]   inst_rdata,
   input  logic                data_req,
   input  logic                data_wr,
   input  logic [1:0]          data_size,
   input  logic [DATA_W/8-1:0] data_wstrb,
   input  logic [ADDR_W-1:0]   data_addr,
   input  logic [DATA_W-1:0]   data_wdata,
   output logic                data_addr_ok,
   output logic                data_data_ok,
   output logic [DATA_W-1:0]   data_rdata,
   output logic                mem_req,
   output logic                mem_wr,
   output logic [1:0]          mem_size,
   output logic [DATA_W/8-1:0] mem_wstrb,
   output logic [ADDR_W-1:0]   mem_addr,
   output logic [DATA_W-1:0]   mem_wdata,
   input  logic                mem_gnt,
   input  logic                mem_rvalid,
   input  logic [DATA_W-1:0]   mem_rdata,
   output logic                arb_err
);

   localparam int PTR_W  = (MAX_OUTST > 1) ? $clog2(MAX_OUTST) : 1;
   localparam int CNT_W  = $clog2(MAX_OUTST + 1);
   localparam int STRB_W = DATA_W / 8;

   logic [MAX_OUTST-1:0] owner_q, owner_d;
   logic [PTR_W-1:0]     rd_ptr_q, rd_ptr_d;
   logic [PTR_W-1:0]     wr_ptr_q, wr_ptr_d;
   logic [CNT_W-1:0]     count_q, count_d;
   logic                 lock_valid_q, lock_valid_d;
   logic                 lock_sel_q, lock_sel_d;
   logic                 arb_err_q, arb_err_d;
`ifdef ARB_ROUND_ROBIN_EN
   logic                 last_grant_q, last_grant_d;
`endif

   logic full, sel, req_int, accept, pop, head;

   function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
      if (p == PTR_W'(MAX_OUTST - 1)) return '0;
      else return p + PTR_W'(1);
   endfunction

   // sel: 1 = data port, 0 = fetch port. A pending lock always wins so fields stay stable until gnt.
   always_comb begin
      full = (count_q == CNT_W'(MAX_OUTST));
      if (lock_valid_q) sel = lock_sel_q;
`ifdef ARB_ROUND_ROBIN_EN
      else if (inst_req && data_req) sel = ~last_grant_q;
`endif
      else sel = data_req;
      req_int = !full && (lock_valid_q || inst_req || data_req);
      accept  = req_int && mem_gnt;
      pop     = mem_rvalid && (count_q != '0);
      head    = owner_q[rd_ptr_q];
   end

   always_comb begin
      owner_d      = owner_q;
      wr_ptr_d     = wr_ptr_q;
      rd_ptr_d     = rd_ptr_q;
      count_d      = count_q;
      lock_valid_d = lock_valid_q;
      lock_sel_d   = lock_sel_q;
      arb_err_d    = arb_err_q;
      if (accept) begin
         owner_d[wr_ptr_q] = sel;
         wr_ptr_d          = ptr_inc(wr_ptr_q);
      end
      if (pop) rd_ptr_d = ptr_inc(rd_ptr_q);
      case ({accept, pop})
         2'b10:   count_d = count_q + CNT_W'(1);
         2'b01:   count_d = count_q - CNT_W'(1);
         default: count_d = count_q;
      endcase
      if (req_int && !mem_gnt) begin
         lock_valid_d = 1'b1;
         lock_sel_d   = sel;
      end else if (accept) begin
         lock_valid_d = 1'b0;
      end
      if (mem_rvalid && (count_q == '0)) arb_err_d = 1'b1;
   end

`ifdef ARB_ROUND_ROBIN_EN
   assign last_grant_d = accept ? sel : last_grant_q;
`endif

   always_ff @(posedge clk or negedge resetn) begin
      if (!resetn) begin
         owner_q      <= '0;
         wr_ptr_q     <= '0;
         rd_ptr_q     <= '0;
         count_q      <= '0;
         lock_valid_q <= 1'b0;
         lock_sel_q   <= 1'b0;
         arb_err_q    <= 1'b0;
`ifdef ARB_ROUND_ROBIN_EN
         last_grant_q <= 1'b0;
`endif
      end else begin
         owner_q      <= owner_d;
         wr_ptr_q     <= wr_ptr_d;
         rd_ptr_q     <= rd_ptr_d;
         count_q      <= count_d;
         lock_valid_q <= lock_valid_d;
         lock_sel_q   <= lock_sel_d;
         arb_err_q    <= arb_err_d;
`ifdef ARB_ROUND_ROBIN_EN
         last_grant_q <= last_grant_d;
`endif
      end
   end

   // Outputs are forced to zero while resetn is low, even though most are combinational.
   always_comb begin
      mem_req      = resetn && req_int;
      mem_wr       = 1'b0;
      mem_size     = 2'd0;
      mem_wstrb    = '0;
      mem_addr     = '0;
      mem_wdata    = '0;
      if (resetn) begin
         if (sel) begin
            mem_wr    = data_wr;
            mem_size  = data_size;
            mem_wstrb = data_wr ? data_wstrb : {STRB_W{1'b0}};
            mem_addr  = data_addr;
            mem_wdata = data_wdata;
         end else begin
            mem_size  = 2'd2;
            mem_addr  = inst_addr;
         end
      end
      inst_addr_ok = resetn && accept && !sel;
      data_addr_ok = resetn && accept && sel;
      inst_data_ok = resetn && pop && !head;
      data_data_ok = resetn && pop && head;
      inst_rdata   = inst_data_ok ? mem_rdata : '0;
      data_rdata   = data_data_ok ? mem_rdata : '0;
      arb_err      = resetn && arb_err_q;
   end

endmodule
